// File: rtl/pet_vitals_engine.sv
// Vitals engine: NUM_STATS saturating stat counters with prescaled decay rounds,
// handshaked player actions, per-stat low flags and a latched death flag.
module pet_vitals_engine #(
    parameter int NUM_STATS   = 6,
    parameter int STAT_W      = 4,
    parameter int TICK_DIV    = 10_000_000,
    parameter int ACTION_GAIN = 3,
    parameter int LOW_THRESH  = 3,
    parameter int DEATH_ZEROS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        action_valid,
    input  logic [2:0]                  action_stat,
    output logic                        action_ready,
    input  logic [STAT_W-1:0]           rand_in,
    output logic [NUM_STATS*STAT_W-1:0] vitals,
    output logic [NUM_STATS-1:0]        low,
    output logic                        alive,
    output logic                        tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int IW = $clog2(NUM_STATS);
    localparam logic [STAT_W-1:0] SMAX = '1;

    typedef enum logic [2:0] {IDLE, COOL, DECAY, CHECK, DEAD} state_t;

    state_t              state_q;
    logic [PW-1:0]       presc_q;
    logic                pending_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       victim_q;
    logic [STAT_W-1:0]   stat_q [NUM_STATS];
    logic                wrap;
    int                  zero_cnt;

    // Sum is formed one bit wider so the clamp sees the true overflow.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] s);
        logic [STAT_W:0] sum;
        sum = {1'b0, s} + (STAT_W+1)'(ACTION_GAIN);
        return (sum > {1'b0, SMAX}) ? SMAX : sum[STAT_W-1:0];
    endfunction

    function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] s,
                                                  input logic [1:0]        amt);
        return (s > STAT_W'(amt)) ? s - STAT_W'(amt) : '0;
    endfunction

    assign wrap         = (state_q != DEAD) && (presc_q == PW'(TICK_DIV - 1));
    assign action_ready = (state_q == IDLE) && alive;

    always_comb begin
        zero_cnt = 0;
        for (int i = 0; i < NUM_STATS; i++)
            if (stat_q[i] == '0) zero_cnt = zero_cnt + 1;
    end

    for (genvar g = 0; g < NUM_STATS; g++) begin : g_out
        assign vitals[g*STAT_W +: STAT_W] = stat_q[g];
        assign low[g] = (stat_q[g] <= STAT_W'(LOW_THRESH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            pending_q <= 1'b0;
            idx_q     <= '0;
            victim_q  <= '0;
            tick      <= 1'b0;
            alive     <= 1'b1;
            for (int i = 0; i < NUM_STATS; i++) stat_q[i] <= SMAX;
        end else begin
            tick <= wrap;
            if (state_q != DEAD) presc_q <= wrap ? '0 : presc_q + 1'b1;
            // A wrap arriving while a tick is already pending is dropped.
            if (wrap && !pending_q) pending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (action_valid) begin
                        for (int i = 0; i < NUM_STATS; i++)
                            if (32'(action_stat) == i) stat_q[i] <= sat_add(stat_q[i]);
                        state_q <= COOL;
                    end else if (pending_q) begin
                        pending_q <= 1'b0;
                        idx_q     <= '0;
                        victim_q  <= IW'(32'(rand_in) % NUM_STATS);
                        state_q   <= DECAY;
                    end
                end
                COOL: state_q <= IDLE;
                DECAY: begin
                    for (int i = 0; i < NUM_STATS; i++)
                        if (32'(idx_q) == i)
                            stat_q[i] <= sat_sub(stat_q[i], (idx_q == victim_q) ? 2'd2 : 2'd1);
                    idx_q <= idx_q + 1'b1;
                    if (32'(idx_q) == NUM_STATS - 1) state_q <= CHECK;
                end
                CHECK: begin
                    if (zero_cnt >= DEATH_ZEROS) begin
                        alive   <= 1'b0;
                        tick    <= 1'b0;
                        state_q <= DEAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
